// File: rtl/ctrl_pipe_hazard_if.sv
// ID-side handshake and per-stage control bus for ctrl_pipe_hazard.
// master = ID/test side, slave = the hazard/pipeline unit.
interface ctrl_pipe_hazard_if #(
    parameter int CTRL_W = 24,
    parameter int DEPTH  = 3
);
    logic                  id_valid;
    logic [CTRL_W-1:0]     id_ctrl;
    logic [4:0]            id_rd;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic                  id_ready;
    logic                  flush_i;
    logic                  mem_stall;
    logic [DEPTH-1:0]      st_valid;
    logic [DEPTH*CTRL_W-1:0] st_ctrl;
    logic [DEPTH*5-1:0]    st_rd;
    logic                  fpu_busy;

    modport master (
        output id_valid, id_ctrl, id_rd, id_rs1, id_rs2,
        output flush_i, mem_stall,
        input  id_ready, st_valid, st_ctrl, st_rd, fpu_busy
    );

    modport slave (
        input  id_valid, id_ctrl, id_rd, id_rs1, id_rs2,
        input  flush_i, mem_stall,
        output id_ready, st_valid, st_ctrl, st_rd, fpu_busy
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control-word pipeline after ID with load-use / FPU-spacing hazard
// detection, branch flush and memory-stall freeze.
module ctrl_pipe_hazard #(
    parameter int CTRL_W    = 24,
    parameter int DEPTH     = 3,
    parameter int FPU_LAT   = 4,
    parameter int MEMRD_BIT = 5,
    parameter int FPU_BIT   = 12,
    parameter int REGW_BIT  = 8
) (
    input  logic clk,
    input  logic rstn,
    ctrl_pipe_hazard_if.slave bus
);
    localparam int CW = $clog2(FPU_LAT + 1);

    // Bad parameter combinations stop elaboration.
    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be >= 1");
    end
    if (FPU_LAT < 1) begin : g_bad_lat
        $error("FPU_LAT must be >= 1");
    end
    if (MEMRD_BIT >= CTRL_W || FPU_BIT >= CTRL_W
        || REGW_BIT >= CTRL_W) begin : g_bad_bits
        $error("control flag index outside control word");
    end

    logic [DEPTH-1:0]  sv;
    logic [CTRL_W-1:0] sc [DEPTH];
    logic [4:0]        sr [DEPTH];
    logic [CW-1:0]     cnt;

    logic load_use;
    logic fpu_hold;
    logic hold;
    logic accept;

    // Hazard detection and ID handshake.
    always_comb begin
        load_use = sv[0] & sc[0][MEMRD_BIT] & (sr[0] != 5'd0)
                 & ((sr[0] == bus.id_rs1) | (sr[0] == bus.id_rs2));
        fpu_hold = bus.id_ctrl[FPU_BIT] & (cnt != '0);
        hold     = bus.id_valid & (load_use | fpu_hold);
        bus.id_ready = ~hold & ~bus.mem_stall & ~bus.flush_i;
        accept   = bus.id_valid & bus.id_ready;
    end

    // Stage registers: flush > stall > accept > bubble for stage 0;
    // later stages shift unless memory stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sv <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sc[k] <= '0;
                sr[k] <= '0;
            end
        end else begin
            if (bus.flush_i) begin
                sv[0] <= 1'b0;
                sc[0] <= '0;
                sr[0] <= '0;
            end else if (bus.mem_stall) begin
                sv[0] <= sv[0];
            end else if (accept) begin
                sv[0] <= 1'b1;
                sc[0] <= bus.id_ctrl;
                sr[0] <= bus.id_rd;
            end else begin
                sv[0] <= 1'b0;
                sc[0] <= '0;
                sr[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (!bus.mem_stall) begin
                    sv[k] <= sv[k-1];
                    sc[k] <= sc[k-1];
                    sr[k] <= sr[k-1];
                end
            end
        end
    end

    // FPU issue-spacing counter; keeps counting through memory stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (accept && bus.id_ctrl[FPU_BIT]) begin
            cnt <= CW'(FPU_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign bus.fpu_busy = (cnt != '0);
    assign bus.st_valid = sv;

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign bus.st_ctrl[g*CTRL_W +: CTRL_W] = sc[g];
        assign bus.st_rd[g*5 +: 5]             = sr[g];
    end
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Self-checking bench for ctrl_pipe_hazard: reset, streaming, load-use,
// FPU spacing (FPU_LAT 4 and 1), flush, memory stall.
module tb_ctrl_pipe_hazard;
    localparam int CW = 24;
    localparam int D  = 3;
    localparam logic [CW-1:0] ALU = 24'h000100;
    localparam logic [CW-1:0] LD  = 24'h000120;
    localparam logic [CW-1:0] FPU = 24'h001100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int q[$];

    ctrl_pipe_hazard_if #(.CTRL_W(CW), .DEPTH(D)) bus ();
    ctrl_pipe_hazard_if #(.CTRL_W(CW), .DEPTH(D)) bus1 ();

    ctrl_pipe_hazard #(.CTRL_W(CW), .DEPTH(D), .FPU_LAT(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave)
    );

    ctrl_pipe_hazard #(.CTRL_W(CW), .DEPTH(D), .FPU_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] rd_at(int k);
        return bus.st_rd[k*5 +: 5];
    endfunction

    function automatic logic [CW-1:0] ctrl_at(int k);
        return bus.st_ctrl[k*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rd    = rd;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
    endtask

    task automatic drain();
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
        repeat (D + 5) step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b1, ALU, 5'd3, 5'd0, 5'd0);
        step();
        step();
        checks++;
        if (bus.st_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid got %b exp 000", bus.st_valid);
        end
        checks++;
        if (bus.fpu_busy !== 1'b0 || bus.st_ctrl !== '0 || bus.st_rd !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b ctrl=%h rd=%h exp 0",
                     bus.fpu_busy, bus.st_ctrl, bus.st_rd);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.id_ready);
        end
        step();
        checks++;
        if (bus.st_valid !== 3'b001 || rd_at(0) !== 5'd3) begin
            errors++;
            $display("FAIL reset_first got v=%b rd=%0d exp v=001 rd=3",
                     bus.st_valid, rd_at(0));
        end
        drain();
    endtask

    task automatic test_streaming();
        int exp_rd;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                drive(1'b1, ALU, 5'(c + 1), 5'd0, 5'd0);
                q.push_back(c + 1);
                #1;
                checks++;
                if (bus.id_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready c=%0d got %b exp 1", c, bus.id_ready);
                end
            end else begin
                drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
            end
            step();
            checks++;
            if (bus.st_valid[2] !== (c >= 2 && c <= 6)) begin
                errors++;
                $display("FAIL stream_v2 c=%0d got %b exp %b", c,
                         bus.st_valid[2], (c >= 2 && c <= 6));
            end
            if (bus.st_valid[2] === 1'b1 && q.size() > 0) begin
                exp_rd = q.pop_front();
                checks++;
                if (rd_at(2) !== 5'(exp_rd)) begin
                    errors++;
                    $display("FAIL stream_rd2 c=%0d got %0d exp %0d", c, rd_at(2), exp_rd);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL stream_left got %0d exp 0", q.size());
        end
        q.delete();
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, LD, 5'd7, 5'd1, 5'd2);
        step();
        drive(1'b1, ALU, 5'd9, 5'd4, 5'd7);
        #1;
        checks++;
        if (bus.id_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall got %b exp 0", bus.id_ready);
        end
        step();
        checks++;
        if (bus.st_valid[0] !== 1'b0 || ctrl_at(0) !== '0 || rd_at(0) !== 5'd0) begin
            errors++;
            $display("FAIL lu_bubble got v=%b ctrl=%h rd=%0d exp 0",
                     bus.st_valid[0], ctrl_at(0), rd_at(0));
        end
        checks++;
        if (bus.st_valid[1] !== 1'b1 || rd_at(1) !== 5'd7) begin
            errors++;
            $display("FAIL lu_load_adv got v=%b rd=%0d exp 1/7", bus.st_valid[1], rd_at(1));
        end
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_release got %b exp 1", bus.id_ready);
        end
        step();
        checks++;
        if (bus.st_valid[0] !== 1'b1 || rd_at(0) !== 5'd9) begin
            errors++;
            $display("FAIL lu_accept got v=%b rd=%0d exp 1/9", bus.st_valid[0], rd_at(0));
        end
        drive(1'b1, LD, 5'd0, 5'd1, 5'd2);
        step();
        drive(1'b1, ALU, 5'd10, 5'd0, 5'd0);
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_x0 got %b exp 1", bus.id_ready);
        end
        step();
        checks++;
        if (bus.st_valid[0] !== 1'b1 || rd_at(0) !== 5'd10) begin
            errors++;
            $display("FAIL lu_x0_acc got v=%b rd=%0d exp 1/10", bus.st_valid[0], rd_at(0));
        end
        drain();
    endtask

    task automatic test_fpu_spacing();
        int waited;
        int busy_n;
        drive(1'b1, FPU, 5'd5, 5'd0, 5'd0);
        #1;
        checks++;
        if (bus.id_ready !== 1'b1 || bus.fpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL fpu_first got rdy=%b busy=%b exp 1/0", bus.id_ready, bus.fpu_busy);
        end
        step();
        drive(1'b1, FPU, 5'd6, 5'd0, 5'd0);
        #1;
        waited = 0;
        busy_n = 0;
        while (bus.id_ready !== 1'b1 && waited < 10) begin
            if (bus.fpu_busy === 1'b1) busy_n++;
            step();
            waited++;
        end
        checks++;
        if (waited != 3) begin
            errors++;
            $display("FAIL fpu_wait got %0d exp 3", waited);
        end
        checks++;
        if (busy_n != 3 || bus.fpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL fpu_busy got n=%0d now=%b exp 3/0", busy_n, bus.fpu_busy);
        end
        step();
        checks++;
        if (rd_at(0) !== 5'd6 || bus.st_valid[0] !== 1'b1 || bus.fpu_busy !== 1'b1) begin
            errors++;
            $display("FAIL fpu_second got rd=%0d v=%b busy=%b exp 6/1/1",
                     rd_at(0), bus.st_valid[0], bus.fpu_busy);
        end
        drain();
        bus1.id_valid = 1'b1;
        bus1.id_ctrl  = FPU;
        bus1.id_rd    = 5'd5;
        step();
        bus1.id_rd = 5'd6;
        #1;
        checks++;
        if (bus1.id_ready !== 1'b1 || bus1.fpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL fpu1_b2b got rdy=%b busy=%b exp 1/0", bus1.id_ready, bus1.fpu_busy);
        end
        step();
        checks++;
        if (bus1.st_rd[4:0] !== 5'd6 || bus1.st_rd[9:5] !== 5'd5) begin
            errors++;
            $display("FAIL fpu1_pipe got %h exp rd0=6 rd1=5", bus1.st_rd);
        end
        bus1.id_valid = 1'b0;
        bus1.id_ctrl  = '0;
        bus1.id_rd    = 5'd0;
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, ALU, 5'd11, 5'd0, 5'd0);
        step();
        drive(1'b1, ALU, 5'd12, 5'd0, 5'd0);
        step();
        drive(1'b1, ALU, 5'd13, 5'd0, 5'd0);
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b exp 0", bus.id_ready);
        end
        step();
        checks++;
        if (bus.st_valid !== 3'b110 || rd_at(1) !== 5'd12 || rd_at(2) !== 5'd11) begin
            errors++;
            $display("FAIL flush_adv got v=%b rd1=%0d rd2=%0d exp 110/12/11",
                     bus.st_valid, rd_at(1), rd_at(2));
        end
        checks++;
        if (ctrl_at(0) !== '0 || rd_at(0) !== 5'd0) begin
            errors++;
            $display("FAIL flush_bubble got ctrl=%h rd=%0d exp 0", ctrl_at(0), rd_at(0));
        end
        bus.flush_i = 1'b0;
        drive(1'b1, ALU, 5'd14, 5'd0, 5'd0);
        step();
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
        bus.mem_stall = 1'b1;
        bus.flush_i   = 1'b1;
        step();
        checks++;
        if (bus.st_valid !== 3'b100 || rd_at(2) !== 5'd12 || ctrl_at(0) !== '0) begin
            errors++;
            $display("FAIL flush_stall got v=%b rd2=%0d ctrl0=%h exp 100/12/0",
                     bus.st_valid, rd_at(2), ctrl_at(0));
        end
        bus.flush_i   = 1'b0;
        bus.mem_stall = 1'b0;
        drain();
    endtask

    task automatic test_stall();
        int exp_rd;
        for (int i = 21; i <= 23; i++) begin
            drive(1'b1, ALU, 5'(i), 5'd0, 5'd0);
            step();
        end
        q.push_back(22);
        q.push_back(23);
        q.push_back(24);
        drive(1'b1, ALU, 5'd24, 5'd0, 5'd0);
        bus.mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.id_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready c=%0d got %b exp 0", c, bus.id_ready);
            end
            step();
            checks++;
            if (bus.st_valid !== 3'b111 || rd_at(0) !== 5'd23
                || rd_at(1) !== 5'd22 || rd_at(2) !== 5'd21) begin
                errors++;
                $display("FAIL stall_hold c=%0d got v=%b rd=%h exp 111/rd 21,22,23",
                         c, bus.st_valid, bus.st_rd);
            end
        end
        bus.mem_stall = 1'b0;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got %b exp 1", bus.id_ready);
        end
        step();
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            exp_rd = q.pop_front();
            checks++;
            if (bus.st_valid[2] !== 1'b1 || rd_at(2) !== 5'(exp_rd)) begin
                errors++;
                $display("FAIL stall_resume c=%0d got v=%b rd=%0d exp 1/%0d",
                         c, bus.st_valid[2], rd_at(2), exp_rd);
            end
            step();
        end
        drain();
        drive(1'b1, FPU, 5'd25, 5'd0, 5'd0);
        step();
        drive(1'b1, ALU, 5'd26, 5'd0, 5'd0);
        bus.mem_stall = 1'b1;
        step();
        checks++;
        if (bus.fpu_busy !== 1'b1 || bus.st_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got busy=%b v0=%b exp 1/1", bus.fpu_busy, bus.st_valid[0]);
        end
        rstn = 1'b0;
        step();
        checks++;
        if (bus.st_valid !== '0 || bus.st_ctrl !== '0 || bus.st_rd !== '0
            || bus.fpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stall got v=%b ctrl=%h rd=%h busy=%b exp 0",
                     bus.st_valid, bus.st_ctrl, bus.st_rd, bus.fpu_busy);
        end
        rstn = 1'b1;
        bus.mem_stall = 1'b0;
        drain();
    endtask

    initial begin
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
        bus.flush_i    = 1'b0;
        bus.mem_stall  = 1'b0;
        bus1.id_valid  = 1'b0;
        bus1.id_ctrl   = '0;
        bus1.id_rd     = 5'd0;
        bus1.id_rs1    = 5'd0;
        bus1.id_rs2    = 5'd0;
        bus1.flush_i   = 1'b0;
        bus1.mem_stall = 1'b0;
        test_reset();
        test_streaming();
        test_load_use();
        test_fpu_spacing();
        test_flush();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
